seq_reduce_apply: RTL and testbench
===================================

# seq_reduce_apply

Parametrised apply-stage reducer for the graph engine: NUM_CH independent lanes, each collapsing runs of consecutive updates to the same destination vertex into one write-back. The block is selectable between min (BFS/SSSP), saturating add (PageRank-style) and max reductions. It sits between the scatter/gather front end and the vertex-BRAM write-back crossbar. Vertex ID 0 is a valid vertex. An explicit flush drains held entries at iteration end, so the final vertex of every lane is written back.

## Interface
- NUM_CH, 4: number of independent lanes.
- DST_ID_DWIDTH, 32: vertex ID width.
- VERTEX_BRAM_DWIDTH, 32: vertex value width.
- WB_VALID_WIDTH, 4: write-back banks; power of two, at least 2. BW = clog2(WB_VALID_WIDTH).
- BANK_LSB, 2: LSB of the bank-select field, dst_id[BANK_LSB +: BW].
- MODE, 0: reduction mode. 0 = unsigned min, 1 = unsigned saturating add, 2 = unsigned max.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_dst_id  in  NUM_CH*DST_ID_DWIDTH  per-lane destination ID; lane k at [k*DST_ID_DWIDTH +: DST_ID_DWIDTH].
- in_data  in  NUM_CH*VERTEX_BRAM_DWIDTH  per-lane update value.
- in_valid  in  NUM_CH  per-lane update strobe.
- flush  in  1  end-of-iteration pulse.
- busy  out  1  high while draining; upstream must hold in_valid low.
- wb_addr  out  NUM_CH*DST_ID_DWIDTH  write-back vertex ID.
- wb_data  out  NUM_CH*VERTEX_BRAM_DWIDTH  write-back value.
- wb_valid  out  NUM_CH*WB_VALID_WIDTH  per-lane one-hot bank strobe.
- flush_done  out  1  one-cycle pulse when the drain completes.
- err_drop  out  1  sticky flag: an input arrived while busy.

## Operation
- Per-lane state: hold_vld, hold_id, hold_data.
- When in_valid[k]=1 and busy=0:
  - hit (hold_vld and hold_id==in_dst_id): hold_data <= R(hold_data, in_data); nothing emitted.
  - miss with hold_vld=1: emit {hold_id, hold_data}; hold <= {in_dst_id, in_data}.
  - miss with hold_vld=0: load hold only; set hold_vld.
- Reduction R:
  - min: smaller value.
  - add: sum saturated to all-ones.
  - max: larger value.
  - Equal values on min/max leave hold_data unchanged.
- Emit:
  - wb_addr/wb_data = held entry.
  - wb_valid[k] bit b = (hold_id[BANK_LSB +: BW] == b), exactly one bit set.
  - When not emitting, lane k drives wb_addr/wb_data/wb_valid to 0.
- Flush FSM, IDLE -> DRAIN -> DONE -> IDLE:
  - IDLE: on flush=1, go to DRAIN. Any in_valid in that same cycle is processed normally first.
  - DRAIN (one cycle): busy=1. Every lane with hold_vld emits its held entry; all hold_vld cleared.
  - DONE (one cycle): busy=1; flush_done=1; returns to IDLE.
  - flush is ignored outside IDLE.
- in_valid[k]=1 while busy=1: input discarded; err_drop set. err_drop is cleared only by rst.
- Lanes are fully independent; no cross-lane merge, even when IDs match.

## Timing
- Registered outputs. Emission caused by an input at edge T appears at T+1, valid for exactly one cycle.
- Flush at edge T:
  - busy high during T+1..T+2.
  - Drain emission visible at T+2, coinciding with flush_done at T+2.
  - New inputs accepted from T+3.
- A flush cycle carrying a miss emits the old held entry at T+1 and the new entry at T+2.
- Throughput: one update per lane per cycle when not busy.
- rst:
  - All outputs, hold_vld, hold_id, hold_data and err_drop = 0; FSM = IDLE.
  - Reset mid-drain discards held entries; no flush_done is issued.
  - Inputs during rst are ignored.

## Test plan
- MODE=0, lane 0:
  - stimulus (5,9),(5,3),(5,7),(6,2), then flush.
  - required: one emit (5,3) at the cycle after (6,2), wb_valid[0]=4'b0010 (bank = id[3:2]=1); drain emits (6,2) with flush_done.
- Vertex 0 with MODE=2, lane 1:
  - stimulus (0,4),(0,8), then flush.
  - required: a single emit (0,8), wb_valid lane 1 = 4'b0001; proves vertex 0 is not a sentinel.
- MODE=1 saturation:
  - stimulus (12,0xFFFFFFF0),(12,0x20), then flush.
  - required: emit (12,0xFFFFFFFF).
- Flush and input in the same cycle, lane 2:
  - held (3,1), new input (4,5) arrives with flush.
  - required: (3,1) at T+1; (4,5) and flush_done at T+2; busy high during T+1..T+2.
- Input while busy:
  - in_valid[3]=1 during a drain cycle.
  - required: no hold change, no emit, err_drop=1 until rst.
- Reset mid-drain:
  - assert rst in the DRAIN cycle.
  - required: next cycle all outputs 0, no flush_done; a following (7,1), flush emits only (7,1).

Source files
------------

// File: rtl/seq_reduce_apply.sv
// Per-lane run-length reducer: merges consecutive updates to one vertex, emits on ID change or flush.
// Registered outputs, one update per lane per cycle; the flush drain holds busy high for two cycles.
module seq_reduce_apply #(
  parameter int NUM_CH             = 4,
  parameter int DST_ID_DWIDTH      = 32,
  parameter int VERTEX_BRAM_DWIDTH = 32,
  parameter int WB_VALID_WIDTH     = 4,
  parameter int BANK_LSB           = 2,
  parameter int MODE               = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CH*DST_ID_DWIDTH-1:0]      in_dst_id,
  input  logic [NUM_CH*VERTEX_BRAM_DWIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]                    in_valid,
  input  logic                                 flush,
  output logic                                 busy,
  output logic [NUM_CH*DST_ID_DWIDTH-1:0]      wb_addr,
  output logic [NUM_CH*VERTEX_BRAM_DWIDTH-1:0] wb_data,
  output logic [NUM_CH*WB_VALID_WIDTH-1:0]     wb_valid,
  output logic                                 flush_done,
  output logic                                 err_drop
);

  localparam int DW = DST_ID_DWIDTH;
  localparam int VW = VERTEX_BRAM_DWIDTH;
  localparam int BW = $clog2(WB_VALID_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Both decode straight from the state register, so they behave as registered outputs.
  assign busy       = (state != IDLE);
  assign flush_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst)                     err_drop <= 1'b0;
    else if (busy && |in_valid)  err_drop <= 1'b1;
  end

  // Equal operands fall through to the held value, so min/max leave it untouched.
  function automatic logic [VW-1:0] reduce_val(input logic [VW-1:0] held,
                                                input logic [VW-1:0] upd);
    logic [VW:0] sum;
    sum = {1'b0, held} + {1'b0, upd};
    case (MODE)
      1:       reduce_val = sum[VW] ? {VW{1'b1}} : sum[VW-1:0];
      2:       reduce_val = (upd > held) ? upd : held;
      default: reduce_val = (upd < held) ? upd : held;
    endcase
  endfunction

  function automatic logic [WB_VALID_WIDTH-1:0] bank_sel(input logic [DW-1:0] id);
    bank_sel = '0;
    bank_sel[id[BANK_LSB +: BW]] = 1'b1;
  endfunction

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [DW-1:0]             lane_id;
    logic [VW-1:0]             lane_data;
    logic                      hold_vld;
    logic [DW-1:0]             hold_id;
    logic [VW-1:0]             hold_data;
    logic                      hit;
    logic [DW-1:0]             emit_addr;
    logic [VW-1:0]             emit_data;
    logic [WB_VALID_WIDTH-1:0] emit_bank;

    assign lane_id   = in_dst_id[k*DW +: DW];
    assign lane_data = in_data[k*VW +: VW];
    assign hit       = hold_vld && (hold_id == lane_id);

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_vld  <= 1'b0;
        hold_id   <= '0;
        hold_data <= '0;
        emit_addr <= '0;
        emit_data <= '0;
        emit_bank <= '0;
      end else begin
        emit_addr <= '0;
        emit_data <= '0;
        emit_bank <= '0;
        if (state == DRAIN) begin
          if (hold_vld) begin
            emit_addr <= hold_id;
            emit_data <= hold_data;
            emit_bank <= bank_sel(hold_id);
          end
          hold_vld <= 1'b0;
        end else if (!busy && in_valid[k]) begin
          if (hit) begin
            hold_data <= reduce_val(hold_data, lane_data);
          end else begin
            if (hold_vld) begin
              emit_addr <= hold_id;
              emit_data <= hold_data;
              emit_bank <= bank_sel(hold_id);
            end
            hold_id   <= lane_id;
            hold_data <= lane_data;
            hold_vld  <= 1'b1;
          end
        end
      end
    end

    assign wb_addr[k*DW +: DW]                             = emit_addr;
    assign wb_data[k*VW +: VW]                             = emit_data;
    assign wb_valid[k*WB_VALID_WIDTH +: WB_VALID_WIDTH]    = emit_bank;
  end

endmodule

// File: tb/tb_seq_reduce_apply.sv
// Directed bench: three instances (min, saturating add, max) share stimulus; checks one at a time.
module tb_seq_reduce_apply;

  logic         clk;
  logic         rst;
  logic [127:0] in_dst_id;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic         flush;

  logic [127:0] wb_addr_o    [3];
  logic [127:0] wb_data_o    [3];
  logic [15:0]  wb_valid_o   [3];
  logic         busy_o       [3];
  logic         flush_done_o [3];
  logic         err_drop_o   [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    seq_reduce_apply #(
      .NUM_CH(4), .DST_ID_DWIDTH(32), .VERTEX_BRAM_DWIDTH(32),
      .WB_VALID_WIDTH(4), .BANK_LSB(2), .MODE(g)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_dst_id  (in_dst_id),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .flush      (flush),
      .busy       (busy_o[g]),
      .wb_addr    (wb_addr_o[g]),
      .wb_data    (wb_data_o[g]),
      .wb_valid   (wb_valid_o[g]),
      .flush_done (flush_done_o[g]),
      .err_drop   (err_drop_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    in_valid  = '0;
    in_dst_id = '0;
    in_data   = '0;
    flush     = 1'b0;
  endtask

  task automatic put(input int k, input logic [31:0] id, input logic [31:0] d);
    in_valid[k]            = 1'b1;
    in_dst_id[k*32 +: 32]  = id;
    in_data[k*32 +: 32]    = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_emit(input string tag, input int d, input int k,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [15:0] vld);
    chk({tag, "_addr"},  {32'd0, wb_addr_o[d][k*32 +: 32]}, {32'd0, addr});
    chk({tag, "_data"},  {32'd0, wb_data_o[d][k*32 +: 32]}, {32'd0, data});
    chk({tag, "_valid"}, {48'd0, wb_valid_o[d]},            {48'd0, vld});
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      chk("rst_addr",  wb_addr_o[d][63:0],       64'd0);
      chk("rst_data",  wb_data_o[d][63:0],       64'd0);
      chk("rst_valid", {48'd0, wb_valid_o[d]},   64'd0);
      chk("rst_busy",  {63'd0, busy_o[d]},       64'd0);
      chk("rst_done",  {63'd0, flush_done_o[d]}, 64'd0);
      chk("rst_err",   {63'd0, err_drop_o[d]},   64'd0);
    end
    rst = 1'b0;

    // min mode, lane 0: run of vertex 5 collapses to 3
    idle_in(); put(0, 5, 9); tick();
    chk("min_run1_noemit", {48'd0, wb_valid_o[0]}, 64'd0);
    idle_in(); put(0, 5, 3); tick();
    chk("min_run2_noemit", {48'd0, wb_valid_o[0]}, 64'd0);
    idle_in(); put(0, 5, 7); tick();
    chk("min_run3_noemit", {48'd0, wb_valid_o[0]}, 64'd0);
    idle_in(); put(0, 6, 2); tick();
    chk_emit("min_miss", 0, 0, 32'd5, 32'd3, 16'h0002);
    idle_in(); flush = 1'b1; tick();
    chk("min_flush_busy1", {63'd0, busy_o[0]}, 64'd1);
    chk("min_flush_gap", {48'd0, wb_valid_o[0]}, 64'd0);
    chk("min_flush_nodone", {63'd0, flush_done_o[0]}, 64'd0);
    idle_in(); tick();
    chk_emit("min_drain", 0, 0, 32'd6, 32'd2, 16'h0002);
    chk("min_drain_done", {63'd0, flush_done_o[0]}, 64'd1);
    chk("min_drain_busy2", {63'd0, busy_o[0]}, 64'd1);
    idle_in(); tick();
    chk("min_idle_busy", {63'd0, busy_o[0]}, 64'd0);
    chk("min_idle_done", {63'd0, flush_done_o[0]}, 64'd0);
    chk("min_idle_valid", {48'd0, wb_valid_o[0]}, 64'd0);

    // max mode, lane 1: vertex 0 is an ordinary vertex
    idle_in(); put(1, 0, 4); tick();
    chk("max_v0_first", {48'd0, wb_valid_o[2]}, 64'd0);
    idle_in(); put(1, 0, 8); tick();
    chk("max_v0_merge", {48'd0, wb_valid_o[2]}, 64'd0);
    idle_in(); flush = 1'b1; tick();
    chk("max_v0_gap", {48'd0, wb_valid_o[2]}, 64'd0);
    idle_in(); tick();
    chk_emit("max_v0_drain", 2, 1, 32'd0, 32'd8, 16'h0010);
    chk("max_v0_done", {63'd0, flush_done_o[2]}, 64'd1);
    idle_in(); tick();

    // saturating add, lane 0
    idle_in(); put(0, 12, 32'hFFFF_FFF0); tick();
    idle_in(); put(0, 12, 32'h0000_0020); tick();
    chk("add_merge_noemit", {48'd0, wb_valid_o[1]}, 64'd0);
    idle_in(); flush = 1'b1; tick();
    idle_in(); tick();
    chk_emit("add_sat", 1, 0, 32'd12, 32'hFFFF_FFFF, 16'h0008);
    idle_in(); tick();

    // flush coinciding with a miss on lane 2
    idle_in(); put(2, 3, 1); tick();
    idle_in(); put(2, 4, 5); flush = 1'b1; tick();
    chk_emit("coflush_old", 0, 2, 32'd3, 32'd1, 16'h0100);
    chk("coflush_busy1", {63'd0, busy_o[0]}, 64'd1);
    chk("coflush_nodone", {63'd0, flush_done_o[0]}, 64'd0);
    idle_in(); tick();
    chk_emit("coflush_new", 0, 2, 32'd4, 32'd5, 16'h0200);
    chk("coflush_done", {63'd0, flush_done_o[0]}, 64'd1);
    chk("coflush_busy2", {63'd0, busy_o[0]}, 64'd1);
    idle_in(); tick();
    chk("coflush_busy_off", {63'd0, busy_o[0]}, 64'd0);
    chk("err_clean_before", {63'd0, err_drop_o[0]}, 64'd0);

    // input on lane 3 during the drain cycle is dropped
    idle_in(); flush = 1'b1; tick();
    idle_in(); put(3, 9, 50); tick();
    chk("busy_in_noemit", {48'd0, wb_valid_o[0]}, 64'd0);
    chk("busy_in_err", {63'd0, err_drop_o[0]}, 64'd1);
    idle_in(); tick();
    chk("busy_in_err_hold", {63'd0, err_drop_o[0]}, 64'd1);
    idle_in(); put(3, 10, 1); tick();
    chk("busy_in_nohold", {48'd0, wb_valid_o[0]}, 64'd0);
    idle_in(); flush = 1'b1; tick();
    idle_in(); tick();
    chk_emit("busy_in_after", 0, 3, 32'd10, 32'd1, 16'h4000);
    chk("busy_in_err_sticky", {63'd0, err_drop_o[0]}, 64'd1);
    idle_in(); tick();

    // reset landing in the drain cycle
    idle_in(); put(0, 8, 4); tick();
    idle_in(); flush = 1'b1; tick();
    chk("rdrain_busy", {63'd0, busy_o[0]}, 64'd1);
    idle_in(); rst = 1'b1; tick();
    chk("rdrain_valid", {48'd0, wb_valid_o[0]}, 64'd0);
    chk("rdrain_addr", {32'd0, wb_addr_o[0][31:0]}, 64'd0);
    chk("rdrain_data", {32'd0, wb_data_o[0][31:0]}, 64'd0);
    chk("rdrain_nodone", {63'd0, flush_done_o[0]}, 64'd0);
    chk("rdrain_busy_off", {63'd0, busy_o[0]}, 64'd0);
    chk("rdrain_err_clr", {63'd0, err_drop_o[0]}, 64'd0);
    rst = 1'b0;
    idle_in(); tick();
    chk("rdrain_still_nodone", {63'd0, flush_done_o[0]}, 64'd0);
    idle_in(); put(0, 7, 1); tick();
    chk("rdrain_discarded", {48'd0, wb_valid_o[0]}, 64'd0);
    idle_in(); flush = 1'b1; tick();
    chk("rdrain_flush_gap", {48'd0, wb_valid_o[0]}, 64'd0);
    idle_in(); tick();
    chk_emit("rdrain_only7", 0, 0, 32'd7, 32'd1, 16'h0002);
    chk("rdrain_done", {63'd0, flush_done_o[0]}, 64'd1);
    idle_in(); tick();
    chk("rdrain_end_valid", {48'd0, wb_valid_o[0]}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
